spi_responder: RTL

//  SPI mode-0 responder (slave): the far end of the system's SPI master (cs/sclk/mosi/miso).

---
 rtl/spi_responder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder (slave) oversampled in the clk_clk domain.
// Receives MSB-first words on spi_mosi and presents each complete word on rx_data
// with a one-cycle rx_valid pulse. Transmits the word held in a one-entry holding
// register on spi_miso. When the holding register is empty at a word boundary, the
// word sent is FILL_BYTE and underrun pulses.
// Optional build macro SPI_RESP_ECHO_EN: when the holding register is empty, the
// last received word is sent back (loopback echo) instead of FILL_BYTE.
module spi_responder #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Pin synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // Transfer state
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-2:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              reload_pend_q;
  logic              seen_rise_q;
  logic              rx_valid_q;
  logic              underrun_q;
  logic              frame_err_q;
  logic              busy_q;

  // Holding register
  logic [DATA_W-1:0] hold_q;
  logic              tx_ready_q;

  // Word-boundary helpers
  logic [DATA_W-1:0] fill_word;
  logic [DATA_W-1:0] reload_word_d;
  logic              load_evt;
  logic [DATA_W-1:0] rx_word;

`ifdef SPI_RESP_ECHO_EN
  assign fill_word = rx_data_q;
`else
  assign fill_word = FILL_BYTE;
`endif

  // Bring the asynchronous SPI pins into the clk_clk domain.
  // The CS chain presets to the idle (deasserted) level so reset exit never
  // looks like a select edge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    // NOTE: every flop here uses non-blocking assignment so each stage samples the
    // previous stage's old value; blocking would collapse the chain to one flop.
    if (reset_reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign rx_word = {rx_shift_q, mosi_s};

  // Decide when the shifter takes a new word and which word it takes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    reload_word_d = tx_ready_q ? fill_word : hold_q;
    load_evt      = 1'b0;
    if (!cs_rise) begin
      load_evt = (state_q == ST_LOAD) ||
                 ((state_q == ST_SHIFT) && sclk_fall && reload_pend_q);
    end
  end

  // Holding register: accept a word only when empty; a word boundary empties it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
    end else if (tx_load && tx_ready_q) begin
      hold_q     <= tx_data;
      tx_ready_q <= 1'b0;
    end else if (load_evt && !tx_ready_q) begin
      tx_ready_q <= 1'b1;
    end
  end

  // Transfer FSM with bit counter, shifters and registered status pulses.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      reload_pend_q <= 1'b0;
      seen_rise_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= ~cs_s;

      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end else begin
            tx_shift_q    <= reload_word_d;
            underrun_q    <= tx_ready_q;
            cnt_q         <= '0;
            reload_pend_q <= 1'b0;
            seen_rise_q   <= 1'b0;
            state_q       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cs_rise) begin
            // A partial word is dropped; whatever is in the shifter is not restored.
            frame_err_q   <= (cnt_q != '0);
            cnt_q         <= '0;
            reload_pend_q <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shift_q  <= rx_word[DATA_W-2:0];
              seen_rise_q <= 1'b1;
              if (cnt_q == CNT_LAST) begin
                rx_data_q     <= rx_word;
                rx_valid_q    <= 1'b1;
                cnt_q         <= '0;
                reload_pend_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (reload_pend_q) begin
                tx_shift_q    <= reload_word_d;
                underrun_q    <= tx_ready_q;
                reload_pend_q <= 1'b0;
              end else if (seen_rise_q) begin
                // A fall before any rise means SCLK was high at select; the first
                // bit must stay on MISO until the master's first rising edge.
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_miso    = tx_shift_q[DATA_W-1];
  assign spi_miso_oe = busy_q;
  assign busy        = busy_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
  assign frame_err   = frame_err_q;

endmodule
